// File: rtl/stage0_fetch_sequencer.sv
// Stage-0 fetch sequencer: assembles 32-bit instructions from four byte reads,
// presents them with valid/ready, and handles jump redirects and a halt opcode.
module stage0_fetch_sequencer #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [7:0]          HALT_OP  = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_data,
  input  logic                mem_ack,
  output logic [31:0]         full_ins,
  output logic [PC_WIDTH-1:0] ins_pc,
  output logic                ins_valid,
  input  logic                ins_ready,
  input  logic                jmp_valid,
  input  logic [PC_WIDTH-1:0] jmp_addr,
  output logic                halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [1:0]          r_byte_idx;
  logic [1:0]          w_byte_idx_next;
  logic [31:0]         r_full_ins;
  logic [31:0]         w_full_ins_next;
  logic [PC_WIDTH-1:0] r_ins_pc;
  logic [PC_WIDTH-1:0] w_ins_pc_next;
  logic [PC_WIDTH-1:0] w_jmp_target;
  logic                w_unused_jmp_lsb;

  assign w_jmp_target     = {jmp_addr[PC_WIDTH-1:2], 2'b00};
  assign w_unused_jmp_lsb = ^jmp_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_byte_idx <= 2'd0;
      r_full_ins <= 32'd0;
      r_ins_pc   <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_byte_idx <= w_byte_idx_next;
      r_full_ins <= w_full_ins_next;
      r_ins_pc   <= w_ins_pc_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_byte_idx_next = r_byte_idx;
    w_full_ins_next = r_full_ins;
    w_ins_pc_next   = r_ins_pc;

    case (r_state)
      S_IDLE: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          w_full_ins_next[8*r_byte_idx +: 8] = mem_data;
          w_byte_idx_next = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            w_ins_pc_next = r_pc;
            w_state_next  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (ins_ready) begin
          w_pc_next    = r_pc + PC_WIDTH'(4);
          w_state_next = (r_full_ins[31:24] == HALT_OP) ? S_HALTED : S_FETCH;
        end
      end
      default: begin
        w_state_next = S_HALTED;
      end
    endcase

    // A redirect overrides everything: partial fetch, same-cycle ack, pc+4 and halt.
    if (jmp_valid) begin
      w_pc_next       = w_jmp_target;
      w_byte_idx_next = 2'd0;
      w_full_ins_next = r_full_ins;
      w_ins_pc_next   = r_ins_pc;
      w_state_next    = S_FETCH;
    end
  end

  assign mem_addr  = r_pc + PC_WIDTH'(r_byte_idx);
  assign mem_rd    = (r_state == S_FETCH);
  assign ins_valid = (r_state == S_HOLD);
  assign halted    = (r_state == S_HALTED);
  assign full_ins  = r_full_ins;
  assign ins_pc    = r_ins_pc;

endmodule
